// File: rtl/uart_prog_loader.sv
// UART 8N1 receiver and sequential 32-bit instruction loader (little-endian byte assembly).
// Optional macro PROG_TIMEOUT_EN adds an inter-byte timeout that drops a stalled partial word.
`timescale 1ns/1ps
module uart_prog_loader #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned WORD_COUNT   = 65,
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned TIMEOUT_BITS = 40
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              rx_i,
    output logic              ready_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       wdata_o,
    output logic              done_o,
    output logic              frame_err_o,
    output logic              timeout_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    logic              rx_meta_q, rxs_q, rxs_prev_q;
    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q;
    logic [1:0]        lane_q;
    logic [ADDR_W-1:0] word_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              done_q, done_d;
    logic              ready_q;
    logic              ferr_q;
    logic              bit_end_c, byte_ok_c, last_wr_c;

`ifdef PROG_TIMEOUT_EN
    localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_q;
`endif

    // Two-flop synchroniser plus one delayed copy for start-edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= rx_i;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    always_comb begin
        bit_end_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
        byte_ok_c = (state_q == S_STOP) && bit_end_c && rxs_q;
        last_wr_c = we_q && (addr_q == ADDR_W'(WORD_COUNT - 1));
        done_d    = done_q | last_wr_c;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            lane_q  <= '0;
            word_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef PROG_TIMEOUT_EN
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
`endif
        end else if (!en_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            lane_q  <= '0;
            word_q  <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef PROG_TIMEOUT_EN
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            we_q    <= 1'b0;
            done_q  <= done_d;
            ready_q <= !done_d;
            if (!done_q) begin
                case (state_q)
                    S_IDLE: begin
                        if (rxs_prev_q && !rxs_q) begin
                            state_q <= S_START;
                            cnt_q   <= '0;
                        end
                    end
                    S_START: begin
                        if (cnt_q == CNT_W'(HALF)) begin
                            cnt_q   <= '0;
                            bit_q   <= '0;
                            state_q <= rxs_q ? S_IDLE : S_DATA;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (bit_end_c) begin
                            cnt_q   <= '0;
                            shift_q <= {rxs_q, shift_q[7:1]};
                            bit_q   <= bit_q + 3'd1;
                            if (bit_q == 3'd7) state_q <= S_STOP;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    S_STOP: begin
                        if (bit_end_c) begin
                            cnt_q   <= '0;
                            state_q <= S_IDLE;
                            if (rxs_q) begin
                                wdata_q[{lane_q, 3'b000} +: 8] <= shift_q;
                                lane_q <= lane_q + 2'd1;
                                if (lane_q == 2'd3) begin
                                    we_q   <= 1'b1;
                                    addr_q <= word_q;
                                    word_q <= word_q + ADDR_W'(1);
                                end
                            end else begin
                                ferr_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
`ifdef PROG_TIMEOUT_EN
                // Timer overrides the FSM so a stalled partial word is abandoned
                if (byte_ok_c || (lane_q == 2'd0 && state_q == S_IDLE)) begin
                    to_cnt_q <= '0;
                end else if (to_cnt_q == TO_W'(TO_LIMIT - 1)) begin
                    to_cnt_q  <= '0;
                    timeout_q <= 1'b1;
                    lane_q    <= '0;
                    state_q   <= S_IDLE;
                end else begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                end
`endif
            end
        end
    end

    assign ready_o     = ready_q;
    assign we_o        = we_q;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign done_o      = done_q;
    assign frame_err_o = ferr_q;
`ifdef PROG_TIMEOUT_EN
    assign timeout_o   = timeout_q;
`else
    // No timer in this build; the parameter only feeds a constant-false term
    assign timeout_o   = 1'b0 && (TIMEOUT_BITS != 0);
`endif

endmodule
